coin_input_conditioner: RTL



---
 rtl/coin_input_conditioner_pkg.sv | 19 +
 rtl/coin_debounce.sv | 74 +++++++
 rtl/coin_input_conditioner.sv | 109 ++++++++++
 3 files changed

// File: rtl/coin_input_conditioner_pkg.sv
// Shared definitions for the coin path: coin codes seen by the vending FSM
// and the state encoding of the acceptance FSM.
package coin_input_conditioner_pkg;

  localparam logic [1:0] COIN_NONE  = 2'b00;
  localparam logic [1:0] COIN_SMALL = 2'b10;
  localparam logic [1:0] COIN_LARGE = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } cic_state_t;

  // Map a single accepted channel to its coin code.
  function automatic logic [1:0] coin_code(input logic i_is_large);
    return i_is_large ? COIN_LARGE : COIN_SMALL;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchronizer, debounce, rising-edge event and
// stuck-high (jam) detection.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int JAM_CYCLES      = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_event,
  output logic o_jam_ch,
  output logic o_level
);

  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int JMW  = $clog2(JAM_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [JMW-1:0] JM_MAX  = JMW'(JAM_CYCLES);

  logic           r_sync1, r_sync2;
  logic           r_level, r_level_d;
  logic [DBW-1:0] r_db_cnt;
  logic [JMW-1:0] r_jam_cnt;
  logic           r_jam;

  // Bring the asynchronous sensor into the clock domain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Level only moves after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_db_cnt  <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_level;
      if (r_sync2 == r_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_level  <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // Count time spent high; saturate and flag jam once the limit is reached.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_jam_cnt <= '0;
      r_jam     <= 1'b0;
    end else begin
      if (!r_level)
        r_jam_cnt <= '0;
      else if (r_jam_cnt != JM_MAX)
        r_jam_cnt <= r_jam_cnt + 1'b1;
      r_jam <= r_level && (r_jam_cnt == JM_MAX);
    end
  end

  assign o_event  = r_level & ~r_level_d;
  assign o_jam_ch = r_jam;
  assign o_level  = r_level;

endmodule

// File: rtl/coin_input_conditioner.sv
// Conditions the two coin sensors into single-cycle coin codes, enforcing a
// minimum gap between coins and flagging rejected coins and jammed sensors.
module coin_input_conditioner
  import coin_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MIN_GAP         = 8,
  parameter int JAM_CYCLES      = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sns_small_raw,
  input  logic       i_sns_large_raw,
  input  logic       i_accept_en,
  output logic [1:0] o_coin,
  output logic       o_reject,
  output logic       o_jam
);

  localparam int GPW = $clog2(MIN_GAP + 1);
  localparam logic [GPW-1:0] GAP_LAST = GPW'(MIN_GAP - 1);

  logic w_ev_small_raw, w_jam_small, w_lvl_small;
  logic w_ev_large_raw, w_jam_large, w_lvl_large;
  logic w_ev_small, w_ev_large, w_any_ev;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_small (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_raw    (i_sns_small_raw),
    .o_event  (w_ev_small_raw),
    .o_jam_ch (w_jam_small),
    .o_level  (w_lvl_small)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_large (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_raw    (i_sns_large_raw),
    .o_event  (w_ev_large_raw),
    .o_jam_ch (w_jam_large),
    .o_level  (w_lvl_large)
  );

  // A jammed channel is silenced entirely: no coin and no reject from it.
  assign w_ev_small = w_ev_small_raw & w_lvl_small & ~w_jam_small;
  assign w_ev_large = w_ev_large_raw & w_lvl_large & ~w_jam_large;
  assign w_any_ev   = w_ev_small | w_ev_large;

  cic_state_t     r_state, w_state_nxt;
  logic [GPW-1:0] r_gap_cnt, w_gap_nxt;
  logic [1:0]     r_coin, w_coin_nxt;
  logic           r_reject, w_reject_nxt;

  // State, gap counter and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
      r_coin    <= COIN_NONE;
      r_reject  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_coin    <= w_coin_nxt;
      r_reject  <= w_reject_nxt;
    end
  end

  // Arbitration and gap timing; coin and reject are mutually exclusive.
  always_comb begin
    w_state_nxt  = r_state;
    w_gap_nxt    = r_gap_cnt;
    w_coin_nxt   = COIN_NONE;
    w_reject_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_ev_small && w_ev_large) begin
          w_reject_nxt = 1'b1;
        end else if (w_any_ev && !i_accept_en) begin
          w_reject_nxt = 1'b1;
        end else if (w_any_ev) begin
          w_coin_nxt  = coin_code(w_ev_large);
          w_state_nxt = ST_GAP;
          w_gap_nxt   = '0;
        end
      end
      ST_GAP: begin
        if (w_any_ev)
          w_reject_nxt = 1'b1;
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_gap_nxt   = '0;
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gap_nxt   = '0;
      end
    endcase
  end

  assign o_coin   = r_coin;
  assign o_reject = r_reject;
  assign o_jam    = w_jam_small | w_jam_large;

endmodule
